// File: rtl/fir_output_capture.sv
// fir_output_capture
// Captures the folded-FIR output stream into cap_mem and compares each captured
// sample against exp_mem, a preloaded expected-vector memory that this block
// only reads. Mismatches are counted and the first failing index is latched.
// The first SKIP valid samples after start are dropped to cover filter fill.
//
// Ports:
//   clk100, rst        clock, asynchronous active-high reset
//   start              one-cycle pulse arming a run (honoured in IDLE/DONE only)
//   din, din_vld       signed sample stream and its valid strobe
//   rd_addr, rd_data   cap_mem readback, one cycle latency
//   busy, done         run in progress / run complete (held)
//   err_cnt            mismatch count of the current/last run
//   first_err_vld/idx  first mismatch seen and its sample index
//   sample_cnt         samples captured in the current/last run
//   signature          MISR over captured samples (FIR_CAP_SIGNATURE_EN only)
//
// Build option: define FIR_CAP_SIGNATURE_EN to add the MISR and signature port.
//
// state     | meaning
// S_IDLE    | out of reset, waiting for start
// S_SKIP    | discarding filter fill-latency samples
// S_CAPTURE | writing and comparing samples
// S_DONE    | DEPTH samples taken, results held until next start
module fir_output_capture #(
  parameter int DW    = 22,
  parameter int DEPTH = 252,
  parameter int AW    = 8,
  parameter int SKIP  = 0
) (
  input  logic          clk100,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] din,
  input  logic          din_vld,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   err_cnt,
  output logic          first_err_vld,
  output logic [AW-1:0] first_err_idx,
  output logic [AW:0]   sample_cnt
`ifdef FIR_CAP_SIGNATURE_EN
 ,output logic [DW-1:0] signature
`endif
);

  localparam int SKW = (SKIP > 1) ? $clog2(SKIP + 1) : 1;
  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_CAPTURE, S_DONE} state_t;

  logic [DW-1:0] cap_mem [0:DEPTH-1];
  logic [DW-1:0] exp_mem [0:DEPTH-1];

  state_t        state_q, state_d;
  logic [SKW-1:0] skip_cnt_q, skip_cnt_d;
  logic [AW:0]   err_cnt_q, err_cnt_d;
  logic [AW:0]   sample_cnt_q, sample_cnt_d;
  logic          first_err_vld_q, first_err_vld_d;
  logic [AW-1:0] first_err_idx_q, first_err_idx_d;
  logic [DW-1:0] rd_data_q;
  logic [AW-1:0] cap_idx;
  logic          accept;
  logic          arm;

  assign cap_idx = sample_cnt_q[AW-1:0];
  assign accept  = din_vld && (state_q == S_CAPTURE);
  // start is only honoured between runs; a start during a run changes nothing.
  assign arm     = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d         = state_q;
    skip_cnt_d      = skip_cnt_q;
    err_cnt_d       = err_cnt_q;
    sample_cnt_d    = sample_cnt_q;
    first_err_vld_d = first_err_vld_q;
    first_err_idx_d = first_err_idx_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        // A din_vld coinciding with start is dropped: the FSM is not yet in
        // SKIP/CAPTURE when that sample is presented.
        if (arm) begin
          skip_cnt_d      = SKW'(SKIP);
          err_cnt_d       = '0;
          sample_cnt_d    = '0;
          first_err_vld_d = 1'b0;
          first_err_idx_d = '0;
          state_d         = (SKIP > 0) ? S_SKIP : S_CAPTURE;
        end
      end
      S_SKIP: begin
        if (din_vld) begin
          if (skip_cnt_q == SKW'(1)) state_d = S_CAPTURE;
          else                       skip_cnt_d = skip_cnt_q - SKW'(1);
        end
      end
      S_CAPTURE: begin
        if (din_vld) begin
          if (din != exp_mem[cap_idx]) begin
            err_cnt_d = err_cnt_q + CNT_ONE;
            if (!first_err_vld_q) begin
              first_err_vld_d = 1'b1;
              first_err_idx_d = cap_idx;
            end
          end
          sample_cnt_d = sample_cnt_q + CNT_ONE;
          if (sample_cnt_q == LAST_IDX) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      skip_cnt_q      <= '0;
      err_cnt_q       <= '0;
      sample_cnt_q    <= '0;
      first_err_vld_q <= 1'b0;
      first_err_idx_q <= '0;
    end else begin
      state_q         <= state_d;
      skip_cnt_q      <= skip_cnt_d;
      err_cnt_q       <= err_cnt_d;
      sample_cnt_q    <= sample_cnt_d;
      first_err_vld_q <= first_err_vld_d;
      first_err_idx_q <= first_err_idx_d;
    end
  end

  // Capture memory has no reset; contents survive rst for post-mortem readback.
  always_ff @(posedge clk100) begin
    if (accept) cap_mem[cap_idx] <= din;
  end

  // Read-before-write: a same-cycle read of the written address returns old data.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= cap_mem[rd_addr];
  end

`ifdef FIR_CAP_SIGNATURE_EN
  logic [DW-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (arm)         sig_d = '0;
    else if (accept) sig_d = {sig_q[DW-2:0], sig_q[DW-1] ^ sig_q[DW-2]} ^ din;
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) sig_q <= '0;
    else     sig_q <= sig_d;
  end

  assign signature = sig_q;
`endif

  assign rd_data       = rd_data_q;
  assign busy          = (state_q == S_SKIP) || (state_q == S_CAPTURE);
  assign done          = (state_q == S_DONE);
  assign err_cnt       = err_cnt_q;
  assign first_err_vld = first_err_vld_q;
  assign first_err_idx = first_err_idx_q;
  assign sample_cnt    = sample_cnt_q;

endmodule

// File: tb/tb_fir_output_capture.sv
`timescale 1ns/1ps
module tb_fir_output_capture;
  localparam int DW = 22;
  localparam int DEPTH = 252;
  localparam int AW = 8;
  localparam logic [DW-1:0] GARBAGE = 22'h3FFFFF;

  typedef struct { int idx; logic [DW-1:0] val; } cap_t;

  logic clk100 = 1'b0;
  always #5 clk100 = ~clk100;
  logic rst;

  logic          start_a, din_vld_a, busy_a, done_a, first_err_vld_a;
  logic [DW-1:0] din_a, rd_data_a;
  logic [AW-1:0] rd_addr_a, first_err_idx_a;
  logic [AW:0]   err_cnt_a, sample_cnt_a;

  logic          start_b, din_vld_b, busy_b, done_b, first_err_vld_b;
  logic [DW-1:0] din_b, rd_data_b;
  logic [AW-1:0] rd_addr_b, first_err_idx_b;
  logic [AW:0]   err_cnt_b, sample_cnt_b;
`ifdef FIR_CAP_SIGNATURE_EN
  logic [DW-1:0] signature_a, signature_b;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] gold [0:DEPTH-1];
  cap_t sb_a[$];
  cap_t sb_b[$];

  fir_output_capture #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .SKIP(0)) dut_a (
    .clk100(clk100), .rst(rst), .start(start_a), .din(din_a), .din_vld(din_vld_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .busy(busy_a), .done(done_a),
    .err_cnt(err_cnt_a), .first_err_vld(first_err_vld_a),
    .first_err_idx(first_err_idx_a), .sample_cnt(sample_cnt_a)
`ifdef FIR_CAP_SIGNATURE_EN
   ,.signature(signature_a)
`endif
  );

  fir_output_capture #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .SKIP(7)) dut_b (
    .clk100(clk100), .rst(rst), .start(start_b), .din(din_b), .din_vld(din_vld_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .busy(busy_b), .done(done_b),
    .err_cnt(err_cnt_b), .first_err_vld(first_err_vld_b),
    .first_err_idx(first_err_idx_b), .sample_cnt(sample_cnt_b)
`ifdef FIR_CAP_SIGNATURE_EN
   ,.signature(signature_b)
`endif
  );

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic send_a(input logic [DW-1:0] v);
    din_a = v;
    din_vld_a = 1'b1;
    tick();
    din_vld_a = 1'b0;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic drain_a(input string name);
    cap_t e;
    while (sb_a.size() > 0) begin
      e = sb_a.pop_front();
      rd_addr_a = AW'(e.idx);
      tick();
      n_cmp++;
      if (rd_data_a !== e.val) begin
        n_err++;
        $display("FAIL %s cap_mem[%0d]: got %h expected %h", name, e.idx, rd_data_a, e.val);
      end
    end
  endtask

  // Full DEPTH-sample run on dut_a at the nominal 1-in-5 rate; bad0/bad1 select
  // samples whose LSB is flipped.
  task automatic capture_run_a(input string name, input int bad0, input int bad1);
    logic [DW-1:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      v = gold[i];
      if (i == bad0 || i == bad1) v = v ^ 22'h000001;
      sb_a.push_back('{i, v});
      send_a(v);
      n_cmp++;
      if (sample_cnt_a !== (AW+1)'(i + 1)) begin
        n_err++;
        $display("FAIL %s sample_cnt after sample %0d: got %0d expected %0d", name, i, sample_cnt_a, i + 1);
      end
      if (i == DEPTH - 2) begin
        n_cmp++;
        if ({busy_a, done_a} !== 2'b10) begin
          n_err++;
          $display("FAIL %s busy/done before last sample: got %b expected 10", name, {busy_a, done_a});
        end
      end
      if (i == DEPTH - 1) begin
        n_cmp++;
        if ({busy_a, done_a} !== 2'b01) begin
          n_err++;
          $display("FAIL %s busy/done on last sample: got %b expected 01", name, {busy_a, done_a});
        end
      end
      repeat (4) tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({busy_a, done_a, first_err_vld_a, err_cnt_a, sample_cnt_a, first_err_idx_a, rd_data_a} !== '0) begin
      n_err++;
      $display("FAIL reset_values: got busy=%b done=%b fev=%b err=%0d cnt=%0d fei=%0d rd=%h expected all 0",
               busy_a, done_a, first_err_vld_a, err_cnt_a, sample_cnt_a, first_err_idx_a, rd_data_a);
    end
`ifdef FIR_CAP_SIGNATURE_EN
    n_cmp++;
    if (signature_a !== '0) begin
      n_err++;
      $display("FAIL reset_signature: got %h expected 0", signature_a);
    end
`endif
    rst = 1'b0;
    tick();
    din_a = 22'h000123;
    din_vld_a = 1'b1;
    repeat (20) tick();
    din_vld_a = 1'b0;
    n_cmp++;
    if ({busy_a, done_a, first_err_vld_a, err_cnt_a, sample_cnt_a, first_err_idx_a} !== '0) begin
      n_err++;
      $display("FAIL idle_ignores_vld: got busy=%b done=%b fev=%b err=%0d cnt=%0d fei=%0d expected all 0",
               busy_a, done_a, first_err_vld_a, err_cnt_a, sample_cnt_a, first_err_idx_a);
    end
  endtask

  task automatic test_golden();
    pulse_start_a();
    n_cmp++;
    if ({busy_a, done_a} !== 2'b10) begin
      n_err++;
      $display("FAIL golden busy after start: got %b expected 10", {busy_a, done_a});
    end
    capture_run_a("golden", -1, -1);
    n_cmp++;
    if (err_cnt_a !== 0 || first_err_vld_a !== 1'b0 || sample_cnt_a !== (AW+1)'(DEPTH)) begin
      n_err++;
      $display("FAIL golden results: got err=%0d fev=%b cnt=%0d expected 0 0 %0d", err_cnt_a, first_err_vld_a, sample_cnt_a, DEPTH);
    end
    send_a(GARBAGE);
    repeat (3) tick();
    n_cmp++;
    if (sample_cnt_a !== (AW+1)'(DEPTH) || done_a !== 1'b1 || err_cnt_a !== 0) begin
      n_err++;
      $display("FAIL done_ignores_vld: got cnt=%0d done=%b err=%0d expected %0d 1 0", sample_cnt_a, done_a, err_cnt_a, DEPTH);
    end
    rd_addr_a = 8'd17;
    tick();
    n_cmp++;
    if (rd_data_a !== gold[17]) begin
      n_err++;
      $display("FAIL readback_17: got %h expected %h", rd_data_a, gold[17]);
    end
    rd_addr_a = 8'd18;
    #2;
    n_cmp++;
    if (rd_data_a !== gold[17]) begin
      n_err++;
      $display("FAIL readback_latency: got %h expected %h (still addr 17)", rd_data_a, gold[17]);
    end
    drain_a("golden");
  endtask

  task automatic test_errors();
    pulse_start_a();
    n_cmp++;
    if (err_cnt_a !== 0 || sample_cnt_a !== 0 || busy_a !== 1'b1 || done_a !== 1'b0) begin
      n_err++;
      $display("FAIL restart_from_done: got err=%0d cnt=%0d busy=%b done=%b expected 0 0 1 0", err_cnt_a, sample_cnt_a, busy_a, done_a);
    end
    capture_run_a("errors", 40, 100);
    n_cmp++;
    if (err_cnt_a !== 2 || first_err_vld_a !== 1'b1 || first_err_idx_a !== 8'd40) begin
      n_err++;
      $display("FAIL error_results: got err=%0d fev=%b fei=%0d expected 2 1 40", err_cnt_a, first_err_vld_a, first_err_idx_a);
    end
    drain_a("errors");
  endtask

  task automatic test_skip();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    n_cmp++;
    if (busy_b !== 1'b1) begin
      n_err++;
      $display("FAIL skip busy after start: got %b expected 1", busy_b);
    end
    din_vld_b = 1'b1;
    din_b = GARBAGE;
    repeat (7) tick();
    n_cmp++;
    if (sample_cnt_b !== 0 || err_cnt_b !== 0) begin
      n_err++;
      $display("FAIL skip_discard: got cnt=%0d err=%0d expected 0 0", sample_cnt_b, err_cnt_b);
    end
    for (int i = 0; i < DEPTH; i++) begin
      din_b = gold[i];
      sb_b.push_back('{i, gold[i]});
      tick();
    end
    din_vld_b = 1'b0;
    n_cmp++;
    if (err_cnt_b !== 0 || sample_cnt_b !== (AW+1)'(DEPTH) || done_b !== 1'b1 || busy_b !== 1'b0 || first_err_vld_b !== 1'b0) begin
      n_err++;
      $display("FAIL skip_results: got err=%0d cnt=%0d done=%b busy=%b fev=%b expected 0 %0d 1 0 0",
               err_cnt_b, sample_cnt_b, done_b, busy_b, first_err_vld_b, DEPTH);
    end
    while (sb_b.size() > 0) begin
      cap_t e;
      e = sb_b.pop_front();
      rd_addr_b = AW'(e.idx);
      tick();
      n_cmp++;
      if (rd_data_b !== e.val) begin
        n_err++;
        $display("FAIL skip cap_mem[%0d]: got %h expected %h", e.idx, rd_data_b, e.val);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] v;
    start_a = 1'b1;
    din_vld_a = 1'b1;
    din_a = GARBAGE;
    tick();
    start_a = 1'b0;
    din_vld_a = 1'b0;
    n_cmp++;
    if (sample_cnt_a !== 0 || err_cnt_a !== 0 || busy_a !== 1'b1) begin
      n_err++;
      $display("FAIL start_with_vld: got cnt=%0d err=%0d busy=%b expected 0 0 1", sample_cnt_a, err_cnt_a, busy_a);
    end
    repeat (4) tick();
    for (int i = 0; i < 120; i++) begin
      v = gold[i];
      if (i == 10) v = v ^ 22'h000001;
      sb_a.push_back('{i, v});
      send_a(v);
      repeat (4) tick();
      if (i == 49) begin
        pulse_start_a();
        n_cmp++;
        if (sample_cnt_a !== 9'd50 || err_cnt_a !== 1 || first_err_vld_a !== 1'b1 || first_err_idx_a !== 8'd10 || busy_a !== 1'b1) begin
          n_err++;
          $display("FAIL start_mid_run: got cnt=%0d err=%0d fev=%b fei=%0d busy=%b expected 50 1 1 10 1",
                   sample_cnt_a, err_cnt_a, first_err_vld_a, first_err_idx_a, busy_a);
        end
      end
    end
    rst = 1'b1;
    #2;
    n_cmp++;
    if ({busy_a, done_a, first_err_vld_a, err_cnt_a, sample_cnt_a, first_err_idx_a, rd_data_a} !== '0) begin
      n_err++;
      $display("FAIL async_rst_mid_run: got busy=%b done=%b fev=%b err=%0d cnt=%0d fei=%0d rd=%h expected all 0",
               busy_a, done_a, first_err_vld_a, err_cnt_a, sample_cnt_a, first_err_idx_a, rd_data_a);
    end
    tick();
    rst = 1'b0;
    tick();
    drain_a("retained");
    pulse_start_a();
    capture_run_a("after_rst", -1, -1);
    n_cmp++;
    if (err_cnt_a !== 0 || done_a !== 1'b1 || sample_cnt_a !== (AW+1)'(DEPTH) || first_err_vld_a !== 1'b0) begin
      n_err++;
      $display("FAIL after_rst results: got err=%0d done=%b cnt=%0d fev=%b expected 0 1 %0d 0", err_cnt_a, done_a, sample_cnt_a, first_err_vld_a, DEPTH);
    end
    drain_a("after_rst");
  endtask

`ifdef FIR_CAP_SIGNATURE_EN
  task automatic test_signature();
    logic [DW-1:0] s;
    logic [DW-1:0] v;
    pulse_start_a();
    n_cmp++;
    if (signature_a !== '0) begin
      n_err++;
      $display("FAIL signature_clear_on_start: got %h expected 0", signature_a);
    end
    s = '0;
    for (int i = 0; i < 4; i++) begin
      v = DW'(1) << i;
      s = {s[DW-2:0], s[DW-1] ^ s[DW-2]} ^ v;
      send_a(v);
      n_cmp++;
      if (signature_a !== s) begin
        n_err++;
        $display("FAIL signature step %0d: got %h expected %h", i, signature_a, s);
      end
      repeat (4) tick();
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    start_a = 1'b0; din_vld_a = 1'b0; din_a = '0; rd_addr_a = '0;
    start_b = 1'b0; din_vld_b = 1'b0; din_b = '0; rd_addr_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      gold[i] = DW'((i * 32'd2654435761) >> 5) ^ DW'(i);
      dut_a.exp_mem[i] = gold[i];
      dut_b.exp_mem[i] = gold[i];
    end
    test_reset();
    test_golden();
    test_errors();
    test_skip();
    test_back_to_back();
`ifdef FIR_CAP_SIGNATURE_EN
    test_signature();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
